// File: rtl/serial_deserializer8.sv
// Serial-in, parallel-out receiver: assembles WIDTH strobed bits into a word and
// presents it through a valid/ack holding register with sticky overrun.
module serial_deserializer8 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     ser_in_i,
  input  logic                     ser_valid_i,
  input  logic                     sync_i,
  input  logic                     data_ack_i,
  output logic [WIDTH-1:0]         data_out_o,
  output logic                     data_valid_o,
  output logic                     overrun_o,
  output logic                     busy_o,
  output logic [$clog2(WIDTH)-1:0] bit_cnt_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;
  logic             capture;
  logic             complete;

  always_comb begin
    if (LSB_FIRST) begin
      shifted = {ser_in_i, shreg_q[WIDTH-1:1]};
    end else begin
      shifted = {shreg_q[WIDTH-2:0], ser_in_i};
    end
    capture  = ser_valid_i && !sync_i;
    complete = capture && (cnt_q == LastCnt);

    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (sync_i) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (capture) begin
      shreg_d = shifted;
      cnt_d   = complete ? '0 : cnt_q + 1'b1;
    end

    // A completing word wins over a plain ack so a same-cycle ack causes no bubble.
    if (complete) begin
      if (!valid_q || data_ack_i) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (data_ack_i) begin
      valid_d = 1'b0;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;
  assign bit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_serial_deserializer8.sv
// Bench for serial_deserializer8: directed scenarios plus randomized traffic,
// checked against a bit-queue reference model; LSB-first and MSB-first instances.
module tb_serial_deserializer8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_in = 1'b0, ser_valid = 1'b0, sync = 1'b0, data_ack = 1'b0;
  logic [7:0] data_out, mdata_out;
  logic       data_valid, overrun, busy, mvalid, movr, mbusy;
  logic [2:0] bit_cnt, mcnt;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit       cur[$];
  bit [7:0] m_data, m_mdata;
  bit       m_valid, m_ovr;

  always #5 clk = ~clk;

  serial_deserializer8 #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
    .clk_i(clk), .reset_ni(reset_n), .ser_in_i(ser_in), .ser_valid_i(ser_valid),
    .sync_i(sync), .data_ack_i(data_ack), .data_out_o(data_out),
    .data_valid_o(data_valid), .overrun_o(overrun), .busy_o(busy), .bit_cnt_o(bit_cnt)
  );

  serial_deserializer8 #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk_i(clk), .reset_ni(reset_n), .ser_in_i(ser_in), .ser_valid_i(ser_valid),
    .sync_i(sync), .data_ack_i(data_ack), .data_out_o(mdata_out),
    .data_valid_o(mvalid), .overrun_o(movr), .busy_o(mbusy), .bit_cnt_o(mcnt)
  );

  task automatic model_reset();
    cur.delete();
    m_data = '0; m_mdata = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // Word from the collected bit list: LSB-first puts bit i at weight 2^i.
  task automatic model_step(input bit in, input bit v, input bit s, input bit a);
    bit done = 1'b0;
    bit [7:0] w = '0, wm = '0;
    if (s) begin
      cur.delete();
      m_ovr = 1'b0;
    end else if (v) begin
      cur.push_back(in);
      if (cur.size() == 8) begin
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
          w[i] = cur[i];
          wm[7-i] = cur[i];
        end
        cur.delete();
      end
    end
    if (done) begin
      if (!m_valid || a) begin
        m_data = w; m_mdata = wm; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (a) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input bit in, input bit v, input bit s, input bit a);
    ser_in = in; ser_valid = v; sync = s; data_ack = a;
    @(posedge clk);
    model_step(in, v, s, a);
    #1;
    ser_valid = 1'b0; sync = 1'b0; data_ack = 1'b0;
  endtask

  task automatic send_word(input bit [7:0] w, input int max_gap, input bit ack_last);
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) begin
        int g = $urandom_range(max_gap, 0);
        for (int k = 0; k < g; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cycle(w[i], 1'b1, 1'b0, ack_last && (i == 7));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #13;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({data_out, data_valid, overrun, busy, bit_cnt} !== 14'h0) begin
      bad++;
      $display("FAIL reset_state: got data=%h v=%b ovr=%b busy=%b cnt=%0d, want all 0",
               data_out, data_valid, overrun, busy, bit_cnt);
    end
    total++;
    if ({mdata_out, mvalid, movr, mbusy, mcnt} !== 14'h0) begin
      bad++;
      $display("FAIL reset_state_msb: got data=%h v=%b, want all 0", mdata_out, mvalid);
    end
  endtask

  task automatic test_a5_every_cycle();
    bit [7:0] w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      cycle(w[i], 1'b1, 1'b0, 1'b0);
      total++;
      if (bit_cnt !== 3'((i + 1) % 8) || busy !== (i != 7)) begin
        bad++;
        $display("FAIL a5_bitcnt[%0d]: got cnt=%0d busy=%b, want cnt=%0d busy=%b",
                 i, bit_cnt, busy, (i + 1) % 8, i != 7);
      end
    end
    total++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL a5_word: got data=%h v=%b ovr=%b, want a5 1 0",
               data_out, data_valid, overrun);
    end
  endtask

  task automatic test_gaps();
    bit [7:0] w = 8'h3C;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int g = $urandom_range(3, 0);
      for (int k = 0; k < g; k++) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bit_cnt !== 3'(i) || data_valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_idle[%0d]: got cnt=%0d v=%b, want cnt=%0d v=0",
                   i, bit_cnt, data_valid, i);
        end
      end
      cycle(w[i], 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL gap_word: got data=%h v=%b, want 3c 1", data_out, data_valid);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h12, 0, 1'b0);
    total++;
    if (data_out !== 8'h12 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: got data=%h v=%b, want 12 1", data_out, data_valid);
    end
    send_word(8'h34, 0, 1'b1);
    total++;
    if (data_out !== 8'h34 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got data=%h v=%b ovr=%b, want 34 1 0",
               data_out, data_valid, overrun);
    end
  endtask

  task automatic test_overrun();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h55, 0, 1'b0);
    send_word(8'hAA, 1, 1'b0);
    total++;
    if (data_out !== 8'h55 || data_valid !== 1'b1 || overrun !== 1'b1 || bit_cnt !== 3'd0) begin
      bad++;
      $display("FAIL overrun_drop: got data=%h v=%b ovr=%b cnt=%0d, want 55 1 1 0",
               data_out, data_valid, overrun, bit_cnt);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (data_valid !== 1'b0 || overrun !== 1'b1 || data_out !== 8'h55) begin
      bad++;
      $display("FAIL overrun_ack: got v=%b ovr=%b data=%h, want 0 1 55",
               data_valid, overrun, data_out);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sync: got ovr=%b, want 0", overrun);
    end
  endtask

  task automatic test_sync_and_async_reset();
    bit [7:0] w = 8'hF0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (bit_cnt !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sync_cnt: got cnt=%0d busy=%b, want 0 0", bit_cnt, busy);
    end
    send_word(w, 0, 1'b0);
    total++;
    if (data_out !== 8'hF0 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL sync_word: got data=%h v=%b, want f0 1", data_out, data_valid);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({data_out, data_valid, overrun, busy, bit_cnt} !== 14'h0) begin
      bad++;
      $display("FAIL async_reset: got data=%h v=%b ovr=%b busy=%b cnt=%0d, want all 0",
               data_out, data_valid, overrun, busy, bit_cnt);
    end
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({data_out, data_valid, overrun, busy, bit_cnt} !== 14'h0) begin
      bad++;
      $display("FAIL reset_idle: got data=%h v=%b cnt=%0d, want all 0",
               data_out, data_valid, bit_cnt);
    end
  endtask

  task automatic test_msb_first_and_loopback();
    bit [7:0] ser_q;
    bit       bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(bits[i], 1'b1, 1'b0, 1'b0);
    total++;
    if (mdata_out !== 8'hA5 || mvalid !== 1'b1) begin
      bad++;
      $display("FAIL msb_a5: got data=%h v=%b, want a5 1", mdata_out, mvalid);
    end
    // Right-shifting serializer: Q[0] goes out first.
    ser_q = 8'hC3;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(ser_q[0], 1'b1, 1'b0, 1'b0);
      ser_q = ser_q >> 1;
    end
    total++;
    if (data_out !== 8'hC3 || mdata_out !== 8'hC3) begin
      bad++;
      $display("FAIL loopback_c3: got lsb=%h msb=%h, want c3 c3", data_out, mdata_out);
    end
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0, ($urandom % 5) == 0);
      total++;
      if ({data_out, data_valid, overrun, busy, bit_cnt} !==
          {m_data, m_valid, m_ovr, cur.size() != 0, 3'(cur.size())}) begin
        bad++;
        $display("FAIL rand[%0d]: got data=%h v=%b ovr=%b busy=%b cnt=%0d, want %h %b %b %b %0d",
                 n, data_out, data_valid, overrun, busy, bit_cnt,
                 m_data, m_valid, m_ovr, cur.size() != 0, cur.size());
      end
      total++;
      if ({mdata_out, mvalid, movr} !== {m_mdata, m_valid, m_ovr}) begin
        bad++;
        $display("FAIL rand_msb[%0d]: got data=%h v=%b ovr=%b, want %h %b %b",
                 n, mdata_out, mvalid, movr, m_mdata, m_valid, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5_every_cycle();
    test_gaps();
    test_back_to_back();
    test_overrun();
    test_sync_and_async_reset();
    test_msb_first_and_loopback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
